// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - lock/flywheel checker for the 7-state cyclic sequence 5-2-7-0-3-1-6.
// Optional saturating mismatch counter port err_count enabled by `define SEQ_CHK_ERRCNT_EN.
module sequence_checker #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [2:0] q_in,
    output logic       locked,
    output logic [2:0] pos,
    output logic       err,
    output logic       illegal
`ifdef SEQ_CHK_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_C   = 3'(LOCK_CNT);
    localparam logic [2:0] UNLOCK_C = 3'(UNLOCK_CNT);
    localparam logic [2:0] SYM_BAD  = 3'd4;
    localparam logic [2:0] SYM_HEAD = 3'd5;

    state_t     state, state_nx;
    logic [2:0] match_cnt, match_nx;
    logic [2:0] miss_cnt, miss_nx;
    logic [2:0] expected, exp_nx;
    logic [2:0] pos_nx;
    logic       err_nx, illegal_nx;

    function automatic logic [2:0] succ(input logic [2:0] s);
        case (s)
            3'd5:    succ = 3'd2;
            3'd2:    succ = 3'd7;
            3'd7:    succ = 3'd0;
            3'd0:    succ = 3'd3;
            3'd3:    succ = 3'd1;
            3'd1:    succ = 3'd6;
            3'd6:    succ = 3'd5;
            default: succ = SYM_HEAD;
        endcase
    endfunction

    function automatic logic [2:0] index_of(input logic [2:0] s);
        case (s)
            3'd5:    index_of = 3'd0;
            3'd2:    index_of = 3'd1;
            3'd7:    index_of = 3'd2;
            3'd0:    index_of = 3'd3;
            3'd3:    index_of = 3'd4;
            3'd1:    index_of = 3'd5;
            3'd6:    index_of = 3'd6;
            default: index_of = 3'd0;
        endcase
    endfunction

    always_comb begin
        state_nx   = state;
        match_nx   = match_cnt;
        miss_nx    = miss_cnt;
        exp_nx     = expected;
        pos_nx     = pos;
        err_nx     = 1'b0;
        illegal_nx = 1'b0;
        if (valid) begin
            illegal_nx = (q_in == SYM_BAD);
            case (state)
                ST_HUNT: begin
                    if (q_in != SYM_BAD) begin
                        exp_nx   = succ(q_in);
                        match_nx = 3'd1;
                        state_nx = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (q_in == expected) begin
                        match_nx = match_cnt + 3'd1;
                        exp_nx   = succ(q_in);
                        if (match_cnt + 3'd1 == LOCK_C) begin
                            state_nx = ST_LOCKED;
                            miss_nx  = 3'd0;
                            pos_nx   = index_of(q_in);
                        end
                    end else if (q_in == SYM_BAD) begin
                        state_nx = ST_HUNT;
                        match_nx = 3'd0;
                        exp_nx   = SYM_HEAD;
                    end else begin
                        match_nx = 3'd1;
                        exp_nx   = succ(q_in);
                    end
                end
                ST_LOCKED: begin
                    if (q_in == expected) begin
                        exp_nx  = succ(q_in);
                        miss_nx = 3'd0;
                        pos_nx  = index_of(q_in);
                    end else begin
                        // An illegal symbol never equals expected, so it lands here as a mismatch
                        err_nx = 1'b1;
                        if (miss_cnt + 3'd1 == UNLOCK_C) begin
                            state_nx = ST_HUNT;
                            match_nx = 3'd0;
                            miss_nx  = 3'd0;
                            exp_nx   = SYM_HEAD;
                            pos_nx   = 3'd0;
                        end else begin
                            miss_nx = miss_cnt + 3'd1;
                            exp_nx  = succ(expected);
                            pos_nx  = (pos == 3'd6) ? 3'd0 : pos + 3'd1;
                        end
                    end
                end
                default: begin
                    state_nx = ST_HUNT;
                    match_nx = 3'd0;
                    miss_nx  = 3'd0;
                    exp_nx   = SYM_HEAD;
                    pos_nx   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            match_cnt <= 3'd0;
            miss_cnt  <= 3'd0;
            expected  <= SYM_HEAD;
            pos       <= 3'd0;
            err       <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nx;
            match_cnt <= match_nx;
            miss_cnt  <= miss_nx;
            expected  <= exp_nx;
            pos       <= pos_nx;
            err       <= err_nx;
            illegal   <= illegal_nx;
        end
    end

    assign locked = (state == ST_LOCKED);

`ifdef SEQ_CHK_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (err_nx && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - directed self-checking bench for sequence_checker (SEQ_CHK_ERRCNT_EN optional).
module tb_sequence_checker;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [2:0] q_in;
    logic       locked;
    logic [2:0] pos;
    logic       err;
    logic       illegal;
`ifdef SEQ_CHK_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int n_chk;
    int n_pass;

    sequence_checker #(.LOCK_CNT(3), .UNLOCK_CNT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .q_in      (q_in),
        .locked    (locked),
        .pos       (pos),
        .err       (err),
        .illegal   (illegal)
`ifdef SEQ_CHK_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input logic v, input logic [2:0] q);
        valid = v;
        q_in  = q;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        valid  = 1'b0;
        q_in   = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_pos", pos, 0);
        check("rst_err", err, 0);
        check("rst_illegal", illegal, 0);
`ifdef SEQ_CHK_ERRCNT_EN
        check("rst_errcnt", err_count, 0);
`endif
        rst_n = 1'b1;

        // acquire lock on 5,2,7 then track the rest of the cycle
        step(1, 3'd5); check("acq1_locked", locked, 0);
        step(1, 3'd2); check("acq2_locked", locked, 0);
        step(1, 3'd7); check("acq3_locked", locked, 1); check("acq3_pos", pos, 2);
        step(1, 3'd0); check("trk_pos3", pos, 3);
        step(1, 3'd3); check("trk_pos4", pos, 4);
        step(1, 3'd1); check("trk_pos5", pos, 5);
        step(1, 3'd6); check("trk_pos6", pos, 6); check("trk_err", err, 0);
        step(1, 3'd5); check("wrap_pos0", pos, 0);

        // single miss flywheels, the flywheel symbol then matches
        step(1, 3'd7); check("miss1_err", err, 1); check("miss1_locked", locked, 1);
        check("miss1_pos", pos, 1);
        step(1, 3'd7); check("fly_err", err, 0); check("fly_pos", pos, 2);
        // miss count was cleared, so one miss keeps lock
        step(1, 3'd5); check("missa_err", err, 1); check("missa_locked", locked, 1);
        check("missa_pos", pos, 3);
        step(1, 3'd4); check("missb_err", err, 1); check("missb_illegal", illegal, 1);
        check("missb_locked", locked, 0); check("missb_pos", pos, 0);
        step(1, 3'd1); check("relock1_err", err, 0); check("relock1_ill", illegal, 0);
        check("relock1_locked", locked, 0);
        step(1, 3'd6); check("relock2_locked", locked, 0);
        step(1, 3'd5); check("relock3_locked", locked, 1); check("relock3_pos", pos, 0);

        // valid low freezes everything
        for (int i = 0; i < 10; i++) begin
            step(0, 3'd4);
            check("frz_locked", locked, 1);
            check("frz_pos", pos, 0);
            check("frz_err", err, 0);
            check("frz_illegal", illegal, 0);
        end
        step(1, 3'd2); check("post_frz_locked", locked, 1); check("post_frz_pos", pos, 1);

        // asynchronous reset between edges
        rst_n = 1'b0;
        #2;
        check("arst_locked", locked, 0);
        check("arst_pos", pos, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 3'd7); check("rlk1_locked", locked, 0);
        step(1, 3'd0); check("rlk2_locked", locked, 0);
        step(1, 3'd3); check("rlk3_locked", locked, 1); check("rlk3_pos", pos, 4);

        // illegal symbol in HUNT and in VERIFY
        rst_pulse();
        step(1, 3'd4); check("hunt4_illegal", illegal, 1); check("hunt4_locked", locked, 0);
        check("hunt4_err", err, 0);
        step(1, 3'd5); check("v5_illegal", illegal, 0);
        step(1, 3'd2); check("v2_locked", locked, 0);
        step(1, 3'd4); check("v4_illegal", illegal, 1); check("v4_locked", locked, 0);
        step(1, 3'd7); check("h7_locked", locked, 0);
        step(1, 3'd0); check("h0_locked", locked, 0);
        step(1, 3'd3); check("h3_locked", locked, 1); check("h3_pos", pos, 4);

        // legal mismatch in VERIFY restarts the run
        rst_pulse();
        step(1, 3'd5);
        step(1, 3'd2);
        step(1, 3'd0); check("rs0_locked", locked, 0);
        step(1, 3'd3); check("rs3_locked", locked, 0);
        step(1, 3'd1); check("rs1_locked", locked, 1); check("rs1_pos", pos, 5);

`ifdef SEQ_CHK_ERRCNT_EN
        rst_pulse();
        for (int i = 0; i < 150; i++) begin
            step(1, 3'd5);
            step(1, 3'd2);
            step(1, 3'd7);
            step(1, 3'd4);
            step(1, 3'd4);
            if (i == 9) check("ecnt_20", err_count, 20);
        end
        check("ecnt_sat", err_count, 255);
        step(1, 3'd5);
        step(1, 3'd2);
        step(1, 3'd7);
        step(1, 3'd4);
        check("ecnt_hold", err_count, 255);
        step(1, 3'd4);
        check("ecnt_unlock", locked, 0);
        check("ecnt_held", err_count, 255);
        rst_pulse();
        check("ecnt_rst", err_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sequence_checker.md
SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 Parameter LOCK_CNT, default 3, meaning: consecutive in-order symbols (range 2..7) required to declare lock.
REQ-002 Parameter UNLOCK_CNT, default 2, meaning: consecutive mismatches while locked (range 1..7) that force loss of lock.
REQ-003 Port clk, input, 1 bit, meaning: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, meaning: asynchronous active-low reset.
REQ-005 Port valid, input, 1 bit, meaning: q_in is sampled on this edge; when low, the edge is ignored.
REQ-006 Port q_in, input, 3 bits, meaning: received symbol from the 7-state cyclic counter.
REQ-007 Port locked, output, 1 bit, meaning: receiver is synchronised to the sequence.
REQ-008 Port pos, output, 3 bits, meaning: index 0..6 of the last accepted symbol in the cycle; 0 when not locked.
REQ-009 Port err, output, 1 bit, meaning: one-cycle pulse for a mismatch detected while locked.
REQ-010 Port illegal, output, 1 bit, meaning: one-cycle pulse when a sampled q_in equals 3'b100.
REQ-011 Port err_count, output, 8 bits, meaning: saturating mismatch count; present only under the configuration macro.

Function
REQ-012 The legal cycle SHALL be 5-2-7-0-3-1-6-5..., indexed pos 0..6 in that order; 4 SHALL never be legal.
REQ-013 succ(x) SHALL be the next symbol of the cycle (succ(6)=5); all outputs SHALL be registered, updating on the sampling edge.
REQ-014 The FSM SHALL have three states: HUNT, VERIFY, LOCKED.
REQ-015 HUNT, valid with legal q_in: expected=succ(q_in), match_cnt=1, go to VERIFY.
REQ-016 HUNT, valid with q_in=4: stay in HUNT; pulse illegal.
REQ-017 VERIFY, q_in==expected: match_cnt+1, expected=succ(q_in); at match_cnt==LOCK_CNT go to LOCKED with miss_cnt=0.
REQ-018 VERIFY, mismatch with legal q_in: restart with match_cnt=1 and expected=succ(q_in); with q_in=4, go to HUNT.
REQ-019 LOCKED, match: expected=succ(q_in), miss_cnt=0, pos=index(q_in).
REQ-020 LOCKED, mismatch: pulse err, miss_cnt+1, flywheel with expected=succ(expected) and pos advancing mod 7.
REQ-021 LOCKED, miss_cnt reaching UNLOCK_CNT: go to HUNT on the same edge; locked and pos return to 0 that edge.
REQ-022 q_in=4 while LOCKED SHALL pulse both illegal and err and count as one mismatch.
REQ-023 err and illegal SHALL be low on any edge where valid=0; valid=0 SHALL freeze all state.
REQ-024 locked SHALL be high exactly while the state is LOCKED.

Reset
REQ-025 rst_n low SHALL immediately force HUNT, match_cnt=0, miss_cnt=0, expected=5, locked=0, pos=0, err=0, illegal=0, err_count=0.
REQ-026 Reset asserted mid-sequence SHALL discard lock; after release, lock SHALL require a full LOCK_CNT run again.

Configuration
REQ-027 With SEQ_CHK_ERRCNT_EN defined: err_count SHALL increment on every err pulse, saturate at 255 and never wrap, and be held across loss of lock.
REQ-028 Without SEQ_CHK_ERRCNT_EN: the err_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Defaults, valid=1, stream 5,2,7 -> locked=1 after the 3rd edge, pos=2; then 0,3,1,6 -> pos=3,4,5,6.
REQ-030 Locked, stream 3 where 0 is expected -> err=1 for one cycle, locked=1; next 3 (flywheel match) -> miss_cnt clears, no err.
REQ-031 Locked, two consecutive wrong symbols -> err pulses twice and locked=0 after the 2nd edge; then 1,6,5 -> relock.
REQ-032 HUNT, q_in=4 -> illegal pulse, state stays HUNT; VERIFY with 5,2,4 -> HUNT, no lock.
REQ-033 Locked mid-stream, rst_n pulsed low between edges -> locked=0, pos=0 immediately; valid=0 for 10 cycles -> no state change.
REQ-034 With SEQ_CHK_ERRCNT_EN, 300 forced mismatches with relock between them -> err_count=255, held; reset -> 0.
